ctrl_fetch_scheduler: RTL
=========================

Name: ctrl_fetch_scheduler

Overview:
- Owns the single-port control-word SRAM (CTRL_60_1024_sky130A class: 1-cycle read latency, active-low CSB/WEB).
- Arbitrates SRAM access between the host load/readback port and run-time instruction fetch.
- In run mode it prefetches control words into a 2-entry buffer and delivers them to the datapath over a valid/ready handshake. It stops on the terminator word (bit 0 set) or on address exhaustion.

Parameters:
ADDR_WIDTH, 10, control SRAM address width; depth = 2**ADDR_WIDTH
CTRL_WIDTH, 60, control word width; bit 0 is the completion/terminator bit
CNT_WIDTH, 32, width of the saturating run-cycle counter

Ports:
CLK_100  in  1  system clock, all logic on rising edge
ARST_N  in  1  asynchronous active-low reset
START  in  1  level; high = run requested, low = host owns SRAM
HOST_ADDR  in  ADDR_WIDTH  host word address
HOST_DIN  in  CTRL_WIDTH  host write data
HOST_EN  in  1  host access request, active high
HOST_WE  in  1  host write when high, read when low
HOST_GRANT  out  1  combinational; host access issued this cycle
HOST_DOUT  out  CTRL_WIDTH  registered host read data; holds until the next host read
SRAM_ADDR  out  ADDR_WIDTH  SRAM address
SRAM_DIN  out  CTRL_WIDTH  SRAM write data
SRAM_CSB  out  1  SRAM chip select, active low
SRAM_WEB  out  1  SRAM write enable, active low
SRAM_DOUT  in  CTRL_WIDTH  SRAM read data, valid the cycle after a read is issued
CTRL_VALID  out  1  CTRL_WORD valid
CTRL_READY  in  1  datapath accepts CTRL_WORD
CTRL_WORD  out  CTRL_WIDTH  buffer head word
COMPLETED  out  1  low only while a run is in progress
RUN_ERROR  out  1  sticky; last address fetched with no terminator
WORD_COUNT  out  ADDR_WIDTH+1  words accepted by the datapath this run
CYCLE_COUNT  out  CNT_WIDTH  cycles spent in RUN and DRAIN, saturating
DEBUG_STATE  out  3  current FSM state

Behaviour:
- Reset (ARST_N low, asynchronous):
  - state IDLE; buffer empty; fetch pointer 0; counters 0.
  - COMPLETED=1, SRAM_CSB=1, SRAM_WEB=1, CTRL_VALID=0, RUN_ERROR=0, HOST_DOUT=0.
- States: IDLE=0, RUN=1, DRAIN=2, DONE=3, ABORT=4.
- IDLE:
  - HOST_GRANT = HOST_EN & ~START. SRAM signals are driven from the host port; CSB = ~HOST_EN, WEB = ~HOST_WE.
  - A granted read loads HOST_DOUT from SRAM_DOUT one cycle later.
  - START high -> RUN. Entering RUN clears fetch pointer, counters and RUN_ERROR. Host requests are ignored in that cycle.
- RUN:
  - Issue a read at the fetch pointer when occupancy + in-flight < 2. Increment the pointer on each issue.
  - Read data is pushed into the buffer the following cycle.
  - Pushed word has bit 0 set -> stop issuing, go to DRAIN. A read already in flight returns data that is discarded.
  - A read issued at address 2**ADDR_WIDTH-1 without terminator -> stop issuing, set RUN_ERROR, go to DRAIN once that word is pushed. The pointer never wraps.
- DRAIN: deliver the remaining buffered words. Once the last word is accepted -> DONE.
- Handshake:
  - CTRL_VALID = buffer non-empty. A transfer occurs when CTRL_VALID & CTRL_READY; on a transfer, pop and increment WORD_COUNT.
  - CTRL_WORD is stable while CTRL_VALID=1 and CTRL_READY=0.
  - A push and pop in the same cycle is allowed when the buffer is full; occupancy is unchanged.
- DONE: COMPLETED=1, counters hold, host port still blocked. START low -> IDLE.
- START low in RUN or DRAIN -> ABORT:
  - flush the buffer; drop CTRL_VALID the next cycle; discard any in-flight data.
  - next cycle -> IDLE. RUN_ERROR and counters hold.
- COMPLETED = 0 in RUN, DRAIN and ABORT; 1 otherwise.
- Latency: START sampled high at edge 0 -> first read issued in cycle 1 -> CTRL_VALID=1 in cycle 3.
- Throughput: 1 word/cycle sustained while CTRL_READY=1.
- Reset mid-run: immediate return to the reset state; SRAM contents are not affected.

Decomposition:
- Package ctrl_fetch_pkg: state encoding constants, DEBUG_STATE width, TERM_BIT=0, SRAM active-low idle levels.
- Sub-module ctrl_fetch_buf: 2-entry FIFO with push, pop, full, empty and occupancy outputs, reset by ARST_N. The scheduler instantiates it once.

Test Plan:
- Host writes words 0x1/0x2 at addresses 0/1, then reads address 1 with START=0 -> HOST_GRANT=1 each cycle; HOST_DOUT=0x2 one cycle after the read.
- Load 0x10, 0x20, 0x31 at addresses 0..2, START=1, CTRL_READY=1 -> CTRL_VALID cycle 3; words 0x10, 0x20, 0x31 on consecutive cycles; WORD_COUNT=3; COMPLETED rises after the last handshake; RUN_ERROR=0.
- Same image with CTRL_READY held low 5 cycles mid-run -> CTRL_WORD stable while stalled; no word lost or duplicated; address 3 is never read.
- No terminator anywhere (all words even) -> fetch stops after address 1023; RUN_ERROR=1; WORD_COUNT=1024; final state DONE.
- START dropped 2 cycles after the first handshake -> state ABORT then IDLE; CTRL_VALID=0 within 1 cycle; host access granted afterwards.
- ARST_N pulsed low during RUN -> all outputs at reset values asynchronously; a rerun from IDLE reproduces the 3-word sequence.

Source files
------------

// File: rtl/ctrl_fetch_pkg.sv
// Shared encodings for the control-word fetch scheduler.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package ctrl_fetch_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_DRAIN = 3'd2,
    ST_DONE  = 3'd3,
    ST_ABORT = 3'd4
  } state_e;

  // Bit of a control word that marks the last word of a program
  localparam int TERM_BIT = 0;

  // SRAM strobes are active low; these are their quiescent levels
  localparam logic SRAM_CSB_IDLE = 1'b1;
  localparam logic SRAM_WEB_IDLE = 1'b1;

endpackage

// File: rtl/ctrl_fetch_buf.sv
// Two-entry prefetch FIFO holding control words between SRAM and datapath.
// Latency: a pushed word is visible at the head the cycle after the push.
// Backpressure: push is dropped when full unless a pop happens the same cycle.
module ctrl_fetch_buf #(
  parameter int WIDTH = 60
) (
  input  logic             CLK_100,
  input  logic             ARST_N,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic             full,
  output logic             empty,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == 2'd0);
  assign full     = (count == 2'd2);
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign head_dat = mem[rd_ptr];

  // Storage, pointers and occupancy; flush empties without touching contents
  always_ff @(posedge CLK_100 or negedge ARST_N) begin
    if (!ARST_N) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      if (do_push && !do_pop) begin
        count <= count + 2'd1;
      end else if (!do_push && do_pop) begin
        count <= count - 2'd1;
      end
    end
  end

endmodule

// File: rtl/ctrl_fetch_scheduler.sv
// Arbitrates the control SRAM between host access and run-time prefetch into a 2-entry buffer.
// Latency: START seen at edge 0 -> read issued cycle 1 -> CTRL_VALID cycle 3; 1 word/cycle sustained.
// Backpressure: CTRL_READY low stalls the buffer; reads are only issued while a slot is free.
module ctrl_fetch_scheduler
  import ctrl_fetch_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int CTRL_WIDTH = 60,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  CLK_100,
  input  logic                  ARST_N,
  input  logic                  START,
  input  logic [ADDR_WIDTH-1:0] HOST_ADDR,
  input  logic [CTRL_WIDTH-1:0] HOST_DIN,
  input  logic                  HOST_EN,
  input  logic                  HOST_WE,
  output logic                  HOST_GRANT,
  output logic [CTRL_WIDTH-1:0] HOST_DOUT,
  output logic [ADDR_WIDTH-1:0] SRAM_ADDR,
  output logic [CTRL_WIDTH-1:0] SRAM_DIN,
  output logic                  SRAM_CSB,
  output logic                  SRAM_WEB,
  input  logic [CTRL_WIDTH-1:0] SRAM_DOUT,
  output logic                  CTRL_VALID,
  input  logic                  CTRL_READY,
  output logic [CTRL_WIDTH-1:0] CTRL_WORD,
  output logic                  COMPLETED,
  output logic                  RUN_ERROR,
  output logic [ADDR_WIDTH:0]   WORD_COUNT,
  output logic [CNT_WIDTH-1:0]  CYCLE_COUNT,
  output logic [STATE_W-1:0]    DEBUG_STATE
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;

  state_e                  state_q;
  state_e                  state_d;
  logic [ADDR_WIDTH-1:0]   ptr_q;
  logic                    infl_q;      // a fetch read was issued last cycle
  logic                    last_q;      // the top address has been issued
  logic                    host_rd_q;   // a host read was issued last cycle

  logic                    buf_full;
  logic                    buf_empty;
  logic [1:0]              buf_cnt;

  logic                    run_active;
  logic                    xfer;
  logic                    flush;
  logic                    push;
  logic                    term_hit;
  logic                    last_push;
  logic                    issue;
  logic [2:0]              slots_used;

  assign CTRL_VALID = ~buf_empty;
  assign SRAM_DIN   = HOST_DIN;

  ctrl_fetch_buf #(
    .WIDTH (CTRL_WIDTH)
  ) u_buf (
    .CLK_100  (CLK_100),
    .ARST_N   (ARST_N),
    .flush    (flush),
    .push     (push),
    .push_dat (SRAM_DOUT),
    .pop      (xfer),
    .head_dat (CTRL_WORD),
    .full     (buf_full),
    .empty    (buf_empty),
    .count    (buf_cnt)
  );

  // Fetch control: which of push / issue / flush happen this cycle.
  // Slots count the read in flight and credit a pop happening now, so a
  // steady stream can issue every cycle with one word buffered.
  always_comb begin
    run_active = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    xfer       = ~buf_empty & CTRL_READY;
    flush      = run_active & ~START;
    push       = (state_q == ST_RUN) & START & infl_q & (~buf_full | xfer);
    term_hit   = push & SRAM_DOUT[TERM_BIT];
    last_push  = push & last_q;
    slots_used = {1'b0, buf_cnt} + {2'b00, infl_q} - {2'b00, xfer};
    issue      = (state_q == ST_RUN) & START & ~last_q & ~term_hit & (slots_used < 3'd2);
  end

  // State register
  always_ff @(posedge CLK_100 or negedge ARST_N) begin
    if (!ARST_N) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (START) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!START)                     state_d = ST_ABORT;
        else if (term_hit || last_push) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!START)                                  state_d = ST_ABORT;
        else if (buf_empty || (buf_cnt == 2'd1 && xfer)) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (!START) state_d = ST_IDLE;
      end
      ST_ABORT: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs: SRAM port mux between host (IDLE only) and the fetch engine
  always_comb begin
    HOST_GRANT  = (state_q == ST_IDLE) & HOST_EN & ~START;
    SRAM_ADDR   = ptr_q;
    SRAM_CSB    = SRAM_CSB_IDLE;
    SRAM_WEB    = SRAM_WEB_IDLE;
    COMPLETED   = ~((state_q == ST_RUN) || (state_q == ST_DRAIN) || (state_q == ST_ABORT));
    DEBUG_STATE = state_q;
    if (HOST_GRANT) begin
      SRAM_ADDR = HOST_ADDR;
      SRAM_CSB  = 1'b0;
      SRAM_WEB  = ~HOST_WE;
    end else if (issue) begin
      SRAM_CSB  = 1'b0;
    end
  end

  // Pointer, run bookkeeping, counters and host read-back register
  always_ff @(posedge CLK_100 or negedge ARST_N) begin
    if (!ARST_N) begin
      ptr_q       <= '0;
      infl_q      <= 1'b0;
      last_q      <= 1'b0;
      host_rd_q   <= 1'b0;
      HOST_DOUT   <= '0;
      RUN_ERROR   <= 1'b0;
      WORD_COUNT  <= '0;
      CYCLE_COUNT <= '0;
    end else begin
      host_rd_q <= HOST_GRANT & ~HOST_WE;
      if (host_rd_q) begin
        HOST_DOUT <= SRAM_DOUT;
      end
      if (state_q == ST_IDLE && START) begin
        ptr_q       <= '0;
        infl_q      <= 1'b0;
        last_q      <= 1'b0;
        RUN_ERROR   <= 1'b0;
        WORD_COUNT  <= '0;
        CYCLE_COUNT <= '0;
      end else begin
        infl_q <= issue;
        // The pointer parks on the top address instead of wrapping
        if (issue) begin
          if (ptr_q == ADDR_MAX) last_q <= 1'b1;
          else                   ptr_q  <= ptr_q + ADDR_WIDTH'(1);
        end
        if (last_push && !SRAM_DOUT[TERM_BIT]) begin
          RUN_ERROR <= 1'b1;
        end
        if (xfer && run_active) begin
          WORD_COUNT <= WORD_COUNT + (ADDR_WIDTH+1)'(1);
        end
        if (run_active && CYCLE_COUNT != '1) begin
          CYCLE_COUNT <= CYCLE_COUNT + CNT_WIDTH'(1);
        end
      end
    end
  end

endmodule
